// File: rtl/rv_pkg.sv
// rv_pkg: shared encodings for the RV32I multicycle core (rv_dp / rv_ctl).
// Holds opcode, funct3, FSM state and instruction-class enums, the datapath
// select encodings (PC_*, WB_*, IMM_*, ALUA_*, ALUB_*, ALU_*), halt causes,
// the control-word struct and the opcode -> class decoder.
// Macro: RV_CTL_SWD_EN makes the custom-0 opcode decode as SWD.
package rv_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_CUST0  = 7'b0001011,
        OP_OPIMM  = 7'b0010011,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3,
        F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7
    } funct3_e;

    localparam logic [2:0] F3_WORD = 3'b010;   // LW/SW width

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MINUS, S_MEM, S_WB, S_JUMP, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LW, CL_SW, CL_BR, CL_JAL, CL_JALR, CL_SWD, CL_ILL
    } cls_e;

    localparam logic       PC_INC    = 1'b0;
    localparam logic       PC_ALU    = 1'b1;
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] IMM_L     = 2'd0;
    localparam logic [1:0] IMM_S     = 2'd1;
    localparam logic [1:0] IMM_B     = 2'd2;
    localparam logic [1:0] IMM_J     = 2'd3;
    localparam logic [1:0] ALUA_REG  = 2'd0;
    localparam logic [1:0] ALUA_PCC  = 2'd1;
    localparam logic       ALUB_REG  = 1'b0;
    localparam logic       ALUB_IMM  = 1'b1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] HC_NONE = 2'd0;
    localparam logic [1:0] HC_ILL  = 2'd1;
    localparam logic [1:0] HC_TMO  = 2'd2;

    typedef struct packed {
        logic       pcsourse;
        logic       pcwrite;
        logic       pccen;
        logic       irwrite;
        logic       regwen;
        logic       mdrwrite;
        logic       aluoutE;
        logic       dataWsel;
        logic       bsel;
        logic [1:0] wbsel;
        logic [1:0] immsel;
        logic [1:0] asel;
        logic [3:0] alusel;
        logic       dmem_re;
        logic       dmem_we;
    } ctl_t;

    localparam ctl_t CTL_DEFAULT = '{
        pcsourse: PC_INC, pcwrite: 1'b0, pccen: 1'b0, irwrite: 1'b0,
        regwen: 1'b0, mdrwrite: 1'b0, aluoutE: 1'b0, dataWsel: 1'b0,
        bsel: ALUB_REG, wbsel: WB_ALUOUT, immsel: IMM_L, asel: ALUA_REG,
        alusel: ALU_ADD, dmem_re: 1'b0, dmem_we: 1'b0
    };

    function automatic cls_e decode_cls(input logic [6:0] op);
        decode_cls = CL_ILL;
        case (op)
            OP_OP:     decode_cls = CL_R;
            OP_OPIMM:  decode_cls = CL_I;
            OP_LOAD:   decode_cls = CL_LW;
            OP_STORE:  decode_cls = CL_SW;
            OP_BRANCH: decode_cls = CL_BR;
            OP_JAL:    decode_cls = CL_JAL;
            OP_JALR:   decode_cls = CL_JALR;
`ifdef RV_CTL_SWD_EN
            OP_CUST0:  decode_cls = CL_SWD;
`endif
            default:   decode_cls = CL_ILL;
        endcase
    endfunction

endpackage

// File: rtl/rv_ctl_if.sv
// rv_ctl_if: control bundle between rv_ctl (master) and rv_dp (slave).
// Carries IR contents, ALU zero flag, memory ready inputs, every datapath
// enable/select, data memory requests and halt status.
interface rv_ctl_if #(parameter int DPWIDTH = 32);
    logic [DPWIDTH-1:0] instr;
    logic               zero;
    logic               imem_ready;
    logic               dmem_ready;
    logic               pcsourse, pcwrite, pccen, irwrite, regwen;
    logic               mdrwrite, aluoutE, dataWsel, bsel;
    logic [1:0]         wbsel, immsel, asel;
    logic [3:0]         alusel;
    logic               dmem_re, dmem_we;
    logic               halted;
    logic [1:0]         halt_cause;

    modport master (
        input  instr, zero, imem_ready, dmem_ready,
        output pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite, aluoutE,
               dataWsel, bsel, wbsel, immsel, asel, alusel, dmem_re, dmem_we,
               halted, halt_cause
    );

    modport slave (
        output instr, zero, imem_ready, dmem_ready,
        input  pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite, aluoutE,
               dataWsel, bsel, wbsel, immsel, asel, alusel, dmem_re, dmem_we,
               halted, halt_cause
    );
endinterface

// File: rtl/rv_alu_dec.sv
// rv_alu_dec: combinational ALU operation decode.
// Ports: cls_i (instruction class), funct3_i, funct7_i in;
//        alusel_o (ALU_* op for R/I classes, ADD otherwise), illegal_o out.
module rv_alu_dec
    import rv_pkg::*;
(
    input  cls_e       cls_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alusel_o,
    output logic       illegal_o
);
    always_comb begin
        alusel_o  = ALU_ADD;
        illegal_o = 1'b0;
        case (cls_i)
            CL_R, CL_I: begin
                case (funct3_i)
                    F3_ADD:  alusel_o = (cls_i == CL_R && funct7_i[5]) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alusel_o = ALU_SLL;
                    F3_SLT:  alusel_o = ALU_SLT;
                    F3_SLTU: alusel_o = ALU_SLTU;
                    F3_XOR:  alusel_o = ALU_XOR;
                    F3_SR:   alusel_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:   alusel_o = ALU_OR;
                    default: alusel_o = ALU_AND;
                endcase
                // funct7 only constrains R-type and the I-type shifts
                if (cls_i == CL_R)
                    illegal_o = !(funct7_i == 7'b0 ||
                                  (funct7_i == 7'b0100000 &&
                                   (funct3_i == F3_ADD || funct3_i == F3_SR)));
                else if (funct3_i == F3_SLL)
                    illegal_o = (funct7_i != 7'b0);
                else if (funct3_i == F3_SR)
                    illegal_o = (funct7_i != 7'b0 && funct7_i != 7'b0100000);
            end
            CL_LW, CL_SW: illegal_o = (funct3_i != F3_WORD);
            CL_BR:        illegal_o = (funct3_i[2:1] != 2'b00);   // BEQ/BNE only
            CL_JALR:      illegal_o = (funct3_i != 3'b000);
            CL_JAL, CL_SWD: illegal_o = 1'b0;                     // SWD ignores funct3
            default:      illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/rv_ctl.sv
// rv_ctl: multicycle control FSM for the RV32I datapath.
// Ports: clk, rst_n (synchronous, active low); bus (rv_ctl_if.master):
//   in  instr, zero, imem_ready, dmem_ready
//   out PC/IR/regfile/MDR/aluout enables, ALU/imm/wb selects, dmem_re/we,
//       halted, halt_cause.
// Parameters: DPWIDTH (instruction width), TIMEOUT (max ready wait, 0 = off).
// Macro: RV_CTL_SWD_EN adds the SWD store-difference instruction (EXEC ->
// MINUS -> MEM with dataWsel=1); otherwise custom-0 halts as illegal.
module rv_ctl
    import rv_pkg::*;
#(
    parameter int DPWIDTH = 32,
    parameter int TIMEOUT = 16
)(
    input  logic     clk,
    input  logic     rst_n,
    rv_ctl_if.master bus
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [1:0]         hc_q, hc_d;
    logic [CW-1:0]      wait_q, wait_d;
    logic [DPWIDTH-1:0] ir;
    cls_e               cls;
    logic [3:0]         dec_alu;
    logic               dec_ill, rdy, tmo, in_wait;
    ctl_t               c;
    logic               unused_ir;

    assign ir        = bus.instr;
    assign unused_ir = ^ir[24:7];
    assign cls       = decode_cls(ir[6:0]);

    rv_alu_dec u_alu_dec (
        .cls_i     (cls),
        .funct3_i  (ir[14:12]),
        .funct7_i  (ir[31:25]),
        .alusel_o  (dec_alu),
        .illegal_o (dec_ill)
    );

    // Wait counter only matters in FETCH (imem) and MEM (dmem).
    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM);
    assign rdy     = (state_q == S_FETCH) ? bus.imem_ready : bus.dmem_ready;
    // Fires on the TIMEOUT-th consecutive not-ready cycle.
    assign tmo     = (TIMEOUT != 0) && !rdy && (32'(wait_q) + 32'd1 >= 32'(TIMEOUT));

    always_comb begin
        c       = CTL_DEFAULT;
        state_d = state_q;
        hc_d    = hc_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    c.irwrite  = 1'b1;
                    c.pccen    = 1'b1;
                    c.pcwrite  = 1'b1;
                    c.pcsourse = PC_INC;
                    state_d    = S_DECODE;
                end else if (tmo) begin
                    state_d = S_HALT;
                    hc_d    = HC_TMO;
                end
            end
            S_DECODE: begin
                // branch/JAL target parked in aluout for EXEC
                c.asel    = ALUA_PCC;
                c.bsel    = ALUB_IMM;
                c.aluoutE = 1'b1;
                if (cls == CL_BR)       c.immsel = IMM_B;
                else if (cls == CL_JAL) c.immsel = IMM_J;
                if (dec_ill) begin
                    state_d = S_HALT;
                    hc_d    = HC_ILL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (cls)
                    CL_R: begin
                        c.alusel  = dec_alu;
                        c.aluoutE = 1'b1;
                        state_d   = S_WB;
                    end
                    CL_I: begin
                        c.bsel    = ALUB_IMM;
                        c.immsel  = IMM_L;
                        c.alusel  = dec_alu;
                        c.aluoutE = 1'b1;
                        state_d   = S_WB;
                    end
                    CL_LW, CL_JALR: begin
                        c.bsel    = ALUB_IMM;
                        c.immsel  = IMM_L;
                        c.aluoutE = 1'b1;
                        state_d   = (cls == CL_LW) ? S_MEM : S_JUMP;
                    end
                    CL_SW, CL_SWD: begin
                        c.bsel    = ALUB_IMM;
                        c.immsel  = IMM_S;
                        c.aluoutE = 1'b1;
`ifdef RV_CTL_SWD_EN
                        state_d   = (cls == CL_SWD) ? S_MINUS : S_MEM;
`else
                        state_d   = S_MEM;
`endif
                    end
                    CL_BR: begin
                        // aluoutE stays 0 so the DECODE target survives
                        c.alusel   = ALU_SUB;
                        c.pcsourse = PC_ALU;
                        c.pcwrite  = ir[12] ? !bus.zero : bus.zero;
                    end
                    CL_JAL: begin
                        c.regwen   = 1'b1;
                        c.wbsel    = WB_PC;
                        c.pcwrite  = 1'b1;
                        c.pcsourse = PC_ALU;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MINUS: begin
                // aluoutE=0: aluout keeps the address, saveminus takes rs1-rs2
                c.alusel = ALU_SUB;
                state_d  = S_MEM;
            end
            S_MEM: begin
                if (cls == CL_LW) begin
                    c.dmem_re  = 1'b1;
                    c.mdrwrite = bus.dmem_ready;
                end else begin
                    c.dmem_we  = 1'b1;
`ifdef RV_CTL_SWD_EN
                    c.dataWsel = (cls == CL_SWD);
`endif
                end
                if (bus.dmem_ready) begin
                    state_d = (cls == CL_LW) ? S_WB : S_FETCH;
                end else if (tmo) begin
                    state_d = S_HALT;
                    hc_d    = HC_TMO;
                end
            end
            S_WB: begin
                c.regwen = 1'b1;
                c.wbsel  = (cls == CL_LW) ? WB_MDR : WB_ALUOUT;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                c.regwen   = 1'b1;
                c.wbsel    = WB_PC;
                c.pcwrite  = 1'b1;
                c.pcsourse = PC_ALU;
                state_d    = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Saturating count of consecutive not-ready cycles within one state.
    always_comb begin
        wait_d = '0;
        if (in_wait && !rdy && state_d == state_q)
            wait_d = (&wait_q) ? wait_q : wait_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            hc_q    <= HC_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            hc_q    <= hc_d;
        end
    end

    assign bus.pcsourse   = c.pcsourse;
    assign bus.pcwrite    = c.pcwrite;
    assign bus.pccen      = c.pccen;
    assign bus.irwrite    = c.irwrite;
    assign bus.regwen     = c.regwen;
    assign bus.mdrwrite   = c.mdrwrite;
    assign bus.aluoutE    = c.aluoutE;
    assign bus.dataWsel   = c.dataWsel;
    assign bus.bsel       = c.bsel;
    assign bus.wbsel      = c.wbsel;
    assign bus.immsel     = c.immsel;
    assign bus.asel       = c.asel;
    assign bus.alusel     = c.alusel;
    assign bus.dmem_re    = c.dmem_re;
    assign bus.dmem_we    = c.dmem_we;
    assign bus.halted     = (state_q == S_HALT);
    assign bus.halt_cause = hc_q;
endmodule

// File: tb/tb_rv_ctl.sv
// tb_rv_ctl: directed bench for rv_ctl (TIMEOUT=16). The bench plays the
// datapath's IR (loads the instruction on the irwrite edge) and the memory
// ready lines, and records per-instruction control activity.
module tb_rv_ctl;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_ctl_if #(.DPWIDTH(32)) bus ();
    rv_ctl #(.DPWIDTH(32), .TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD  = 32'h00108133;  // add  x2,x1,x1
    localparam logic [31:0] I_SUB  = 32'h401101B3;  // sub  x3,x2,x1
    localparam logic [31:0] I_SRAI = 32'h4020D213;  // srai x4,x1,2
    localparam logic [31:0] I_BEQ  = 32'h00108463;  // beq  x1,x1,+8
    localparam logic [31:0] I_BNE  = 32'h00109463;  // bne  x1,x1,+8
    localparam logic [31:0] I_JAL  = 32'h010000EF;  // jal  x1,+16
    localparam logic [31:0] I_JALR = 32'h000100E7;  // jalr x1,0(x2)
    localparam logic [31:0] I_LW   = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] I_SW   = 32'h0020A223;  // sw   x2,4(x1)
    localparam logic [31:0] I_SWD  = 32'h0020A20B;  // swd  x2,4(x1)
    localparam logic [31:0] I_MUL  = 32'h02108133;  // funct7=1: not RV32I
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    typedef struct {
        int ncyc, nfetch, nreg, regcyc, regwb, npca, pcacyc;
        int nmdr, nre, nwe, nwsel, asel2, imm2, alu3, bsel3, imm3;
    } res_t;

    int nvec = 0;
    int nerr = 0;
    bit at_neg = 1'b0;   // previous run stopped mid-cycle in the next FETCH

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        at_neg = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One instruction from its FETCH cycle up to (not incl.) the next fetch.
    task automatic run(input logic [31:0] ins, input logic z, input int ilat,
                       input int dlat, output res_t r);
        bit fetched = 1'b0;
        bit fi;
        int dcnt = 0;
        r = '{default: 0};
        bus.zero = z;
        for (int c = 0; c < 64; c++) begin
            bus.imem_ready = fetched || (c >= ilat);
            bus.dmem_ready = (dcnt >= dlat);
            if (at_neg) begin at_neg = 1'b0; #1; end
            else @(negedge clk);
            if (fetched && bus.irwrite) begin at_neg = 1'b1; break; end
            r.ncyc++;
            if (bus.irwrite && bus.pccen && bus.pcwrite && bus.pcsourse == PC_INC) r.nfetch++;
            if (bus.regwen) begin r.nreg++; r.regcyc = r.ncyc; r.regwb = int'(bus.wbsel); end
            if (bus.pcwrite && bus.pcsourse == PC_ALU) begin r.npca++; r.pcacyc = r.ncyc; end
            if (bus.mdrwrite) r.nmdr++;
            if (bus.dmem_re) begin r.nre++; dcnt++; end
            if (bus.dmem_we) begin r.nwe++; dcnt++; end
            if (bus.dataWsel) r.nwsel++;
            if (r.ncyc == 2) begin r.asel2 = int'(bus.asel); r.imm2 = int'(bus.immsel); end
            if (r.ncyc == 3) begin
                r.alu3 = int'(bus.alusel); r.bsel3 = int'(bus.bsel); r.imm3 = int'(bus.immsel);
            end
            fi = bus.irwrite && !fetched;
            @(posedge clk); #1;
            if (fi) begin fetched = 1'b1; bus.instr = ins; end
        end
    endtask

    // Fetch an instruction that must halt as illegal right after DECODE.
    task automatic ill_test(input string tag, input logic [31:0] ins);
        do_reset();
        bus.imem_ready = 1'b1;
        @(posedge clk); #1;
        bus.instr = ins;
        chk({tag, "_decode_halted"}, int'(bus.halted), 0);
        chk({tag, "_decode_aluoutE"}, int'(bus.aluoutE), 1);
        @(posedge clk); #1;
        chk({tag, "_halted"}, int'(bus.halted), 1);
        chk({tag, "_cause"}, int'(bus.halt_cause), int'(HC_ILL));
        chk({tag, "_irwrite"}, int'(bus.irwrite), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        res_t r;
        int tot;
        bus.instr = 32'h0;
        bus.zero = 1'b0;
        do_reset();
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_cause", int'(bus.halt_cause), 0);
        chk("rst_irwrite", int'(bus.irwrite), 0);
        chk("rst_dmem", int'({bus.dmem_re, bus.dmem_we}), 0);
        chk("rst_regwen", int'(bus.regwen), 0);

        run(I_ADDI, 1'b0, 0, 0, r);
        chk("addi_cycles", r.ncyc, 4);
        chk("addi_fetch", r.nfetch, 1);
        chk("addi_regwen_cyc", r.regcyc, 4);
        chk("addi_wbsel", r.regwb, int'(WB_ALUOUT));
        chk("addi_decode_asel", r.asel2, int'(ALUA_PCC));
        chk("addi_alu", r.alu3, int'(ALU_ADD));
        chk("addi_bsel", r.bsel3, int'(ALUB_IMM));
        tot = r.ncyc;
        run(I_ADD, 1'b0, 0, 0, r);
        chk("add_regwen_abs_cyc", tot + r.regcyc, 8);
        chk("add_nreg", r.nreg, 1);
        chk("add_bsel", r.bsel3, int'(ALUB_REG));
        run(I_SUB, 1'b0, 0, 0, r);
        chk("sub_alu", r.alu3, int'(ALU_SUB));
        run(I_SRAI, 1'b0, 0, 0, r);
        chk("srai_alu", r.alu3, int'(ALU_SRA));
        chk("srai_imm", r.imm3, int'(IMM_L));

        run(I_BEQ, 1'b1, 0, 0, r);
        chk("beq_cycles", r.ncyc, 3);
        chk("beq_taken", r.npca, 1);
        chk("beq_pcalu_cyc", r.pcacyc, 3);
        chk("beq_immsel", r.imm2, int'(IMM_B));
        chk("beq_alu", r.alu3, int'(ALU_SUB));
        run(I_BEQ, 1'b0, 0, 0, r);
        chk("beq_nottaken", r.npca, 0);
        run(I_BNE, 1'b1, 0, 0, r);
        chk("bne_nottaken", r.npca, 0);
        chk("bne_cycles", r.ncyc, 3);
        run(I_BNE, 1'b0, 0, 0, r);
        chk("bne_taken", r.npca, 1);

        run(I_JAL, 1'b0, 0, 0, r);
        chk("jal_cycles", r.ncyc, 3);
        chk("jal_immsel", r.imm2, int'(IMM_J));
        chk("jal_regwen_cyc", r.regcyc, 3);
        chk("jal_pcalu_cyc", r.pcacyc, 3);
        chk("jal_wbsel", r.regwb, int'(WB_PC));
        run(I_JALR, 1'b0, 0, 0, r);
        chk("jalr_cycles", r.ncyc, 4);
        chk("jalr_regwen_cyc", r.regcyc, 4);
        chk("jalr_pcalu_cyc", r.pcacyc, 4);

        run(I_LW, 1'b0, 0, 3, r);
        chk("lw_wait_cycles", r.ncyc, 8);
        chk("lw_wait_re", r.nre, 4);
        chk("lw_wait_mdr", r.nmdr, 1);
        chk("lw_wait_regwen_cyc", r.regcyc, 8);
        chk("lw_wbsel", r.regwb, int'(WB_MDR));
        run(I_LW, 1'b0, 0, 0, r);
        chk("lw_cycles", r.ncyc, 5);
        run(I_SW, 1'b0, 0, 0, r);
        chk("sw_cycles", r.ncyc, 4);
        chk("sw_we", r.nwe, 1);
        chk("sw_imm", r.imm3, int'(IMM_S));
        chk("sw_nreg", r.nreg, 0);
        chk("sw_dataWsel", r.nwsel, 0);
        run(I_SW, 1'b0, 0, 2, r);
        chk("sw_wait_cycles", r.ncyc, 6);
        chk("sw_wait_we", r.nwe, 3);
        run(I_ADDI, 1'b0, 3, 0, r);
        chk("fetch_wait_cycles", r.ncyc, 7);
        chk("fetch_wait_fetch", r.nfetch, 1);
`ifdef RV_CTL_SWD_EN
        run(I_SWD, 1'b0, 0, 0, r);
        chk("swd_cycles", r.ncyc, 5);
        chk("swd_we", r.nwe, 1);
        chk("swd_dataWsel", r.nwsel, 1);
`else
        ill_test("swd_off", I_SWD);
`endif

        ill_test("opc7f", I_BAD);
        repeat (3) @(posedge clk);
        #1;
        chk("opc7f_stays_halted", int'(bus.halted), 1);
        ill_test("mul", I_MUL);

        do_reset();
        chk("after_halt_rst_halted", int'(bus.halted), 0);
        chk("after_halt_rst_cause", int'(bus.halt_cause), 0);
        repeat (15) @(posedge clk);
        #1;
        chk("imem_tmo_15", int'(bus.halted), 0);
        @(posedge clk); #1;
        chk("imem_tmo_16", int'(bus.halted), 1);
        chk("imem_tmo_cause", int'(bus.halt_cause), int'(HC_TMO));

        do_reset();
        run(I_LW, 1'b0, 0, 1000, r);
        chk("dmem_tmo_re", r.nre, 16);
        chk("dmem_tmo_mdr", r.nmdr, 0);
        chk("dmem_tmo_halted", int'(bus.halted), 1);
        chk("dmem_tmo_cause", int'(bus.halt_cause), int'(HC_TMO));
        chk("dmem_tmo_re_dropped", int'(bus.dmem_re), 0);

        // reset while a load is waiting in MEM
        do_reset();
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        @(posedge clk); #1;
        bus.instr = I_LW;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_re_before", int'(bus.dmem_re), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.imem_ready = 1'b0;
        #1;
        chk("midrst_re_after", int'(bus.dmem_re), 0);
        chk("midrst_halted", int'(bus.halted), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
